// File: rtl/dig_in_pkg.sv
// Shared definitions for the digital input port: register offsets, base address
// and the bus handshake state type.
package dig_in_pkg;

  localparam logic [31:0] DIP_BASE_ADDR = 32'h0200_0800;

  localparam logic [3:0] DIP_OFS_DATA = 4'h0;
  localparam logic [3:0] DIP_OFS_RISE = 4'h4;
  localparam logic [3:0] DIP_OFS_FALL = 4'h8;
  localparam logic [3:0] DIP_OFS_STAT = 4'hC;

  typedef enum logic [1:0] {
    DIP_IDLE,
    DIP_ACK,
    DIP_HOLD
  } dip_bus_st_t;

endpackage

// File: rtl/dip_chan_filt.sv
// One input channel: synchronizer chain, debounce counter, filtered level and
// single-cycle rise/fall indications aligned with the edge where filt changes.
module dip_chan_filt #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_LEN     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic filt,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_sr;
  logic                   sync;
  logic                   upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_sr <= '0;
    else        sync_sr <= {sync_sr[SYNC_STAGES-2:0], pin};
  end

  assign sync = sync_sr[SYNC_STAGES-1];

  generate
    if (DEB_LEN == 0) begin : g_nodeb
      assign upd = sync ^ filt;
    end else begin : g_deb
      localparam int unsigned CW = $clog2(DEB_LEN + 1);
      logic [CW-1:0] cnt;

      // upd fires on the DEB_LEN-th consecutive edge that sees sync != filt
      assign upd = (sync != filt) && (cnt == CW'(DEB_LEN - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   cnt <= '0;
        else if ((sync == filt) || upd) cnt <= '0;
        else                          cnt <= cnt + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   filt <= 1'b0;
    else if (upd) filt <= sync;
  end

  assign rise = upd & sync;
  assign fall = upd & ~sync;

endmodule

// File: rtl/dig_in_port_irq.sv
// Bus-mapped filtered input port with per-channel rise/fall edge capture and a
// level interrupt; one transaction per strobe assertion.
module dig_in_port_irq
  import dig_in_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_LEN     = 4
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic [WIDTH-1:0] iDIn,
  input  logic [31:0]      iADR,
  input  logic [31:0]      iDAT,
  input  logic             iWE,
  input  logic             iSTB,
  output logic [31:0]      oDAT,
  output logic             oACK,
  output logic             oIRQ
);

  logic [WIDTH-1:0] filt, rise, fall;
  logic [WIDTH-1:0] rise_en, fall_en, status, w1c;
  logic [3:0]       ofs;
  logic             wr_fire;
  logic [31:0]      rd_data;
  dip_bus_st_t      st;

  assign ofs     = {iADR[3:2], 2'b00};
  assign wr_fire = (st == DIP_IDLE) && iSTB && iWE;
  assign w1c     = (wr_fire && (ofs == DIP_OFS_STAT)) ? iDAT[WIDTH-1:0] : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    dip_chan_filt #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_LEN    (DEB_LEN)
    ) u_filt (
      .clk  (iCLK),
      .rst_n(iRSTn),
      .pin  (iDIn[i]),
      .filt (filt[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // capture is ORed in after the clear so a same-cycle set beats W1C
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
    end else begin
      if (wr_fire && (ofs == DIP_OFS_RISE)) rise_en <= iDAT[WIDTH-1:0];
      if (wr_fire && (ofs == DIP_OFS_FALL)) fall_en <= iDAT[WIDTH-1:0];
      status <= (status & ~w1c) | (rise & rise_en) | (fall & fall_en);
    end
  end

  always_comb begin
    rd_data = '0;
    case (ofs)
      DIP_OFS_DATA: rd_data = 32'(filt);
      DIP_OFS_RISE: rd_data = 32'(rise_en);
      DIP_OFS_FALL: rd_data = 32'(fall_en);
      DIP_OFS_STAT: rd_data = 32'(status);
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      st   <= DIP_IDLE;
      oACK <= 1'b0;
      oDAT <= '0;
    end else begin
      case (st)
        DIP_IDLE: begin
          if (iSTB) begin
            st   <= DIP_ACK;
            oACK <= 1'b1;
            oDAT <= rd_data;
          end
        end
        DIP_ACK: begin
          oACK <= 1'b0;
          oDAT <= '0;
          st   <= iSTB ? DIP_HOLD : DIP_IDLE;
        end
        DIP_HOLD: begin
          if (!iSTB) st <= DIP_IDLE;
        end
        default: begin
          st   <= DIP_IDLE;
          oACK <= 1'b0;
          oDAT <= '0;
        end
      endcase
    end
  end

  assign oIRQ = |status;

  logic unused_adr;
  assign unused_adr = &{1'b0, iADR[31:4], iADR[1:0]};

  if (WIDTH < 32) begin : g_unused_dat
    logic unused_dat;
    assign unused_dat = &{1'b0, iDAT[31:WIDTH]};
  end

endmodule

// File: tb/tb_dig_in_port_irq.sv
// Self-checking bench for dig_in_port_irq with directed scenarios and a
// randomized run against a history-based behavioural model.
module tb_dig_in_port_irq;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  logic        iCLK  = 1'b0;
  logic        iRSTn = 1'b1;
  logic [7:0]  iDIn  = '0;
  logic [31:0] iADR  = '0;
  logic [31:0] iDAT  = '0;
  logic        iWE   = 1'b0;
  logic        iSTB  = 1'b0;
  logic [31:0] oDAT;
  logic        oACK;
  logic        oIRQ;

  int vectors     = 0;
  int miscompares = 0;

  dig_in_port_irq #(.WIDTH(8), .SYNC_STAGES(SYNC), .DEB_LEN(DEB)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iDIn(iDIn), .iADR(iADR), .iDAT(iDAT),
    .iWE(iWE), .iSTB(iSTB), .oDAT(oDAT), .oACK(oACK), .oIRQ(oIRQ)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model: pin sample history, sync history, register values.
  logic [7:0]  m_pins[$];
  logic [7:0]  m_syncs[$];
  logic [7:0]  m_filt, m_rise, m_fall, m_status;
  logic        m_busy, m_wr;
  logic [1:0]  m_wofs;
  logic [7:0]  m_wdat;
  logic [31:0] m_snap;

  function automatic logic [31:0] model_reg(input logic [1:0] o);
    case (o)
      2'd0:    return {24'h0, m_filt};
      2'd1:    return {24'h0, m_rise};
      2'd2:    return {24'h0, m_fall};
      default: return {24'h0, m_status};
    endcase
  endfunction

  task automatic model_reset();
    m_pins.delete();
    m_syncs.delete();
    m_filt = '0; m_rise = '0; m_fall = '0; m_status = '0;
    m_busy = 1'b0; m_wr = 1'b0; m_wofs = '0; m_wdat = '0; m_snap = '0;
  endtask

  task automatic model_step();
    logic [7:0] sb, newf, rs, fl, w1c, s;
    logic       alld;
    // sync seen at this edge is the pin value sampled SYNC edges earlier
    sb = (m_pins.size() == SYNC) ? m_pins[0] : 8'h00;
    m_pins.push_back(iDIn);
    if (m_pins.size() > SYNC) void'(m_pins.pop_front());
    m_syncs.push_back(sb);
    if (m_syncs.size() > DEB) void'(m_syncs.pop_front());
    newf = m_filt;
    for (int i = 0; i < 8; i++) begin
      alld = (m_syncs.size() == DEB);
      for (int j = 0; j < m_syncs.size(); j++) begin
        s = m_syncs[j];
        if (s[i] == m_filt[i]) alld = 1'b0;
      end
      if (alld) newf[i] = ~m_filt[i];
    end
    rs  = newf & ~m_filt & m_rise;
    fl  = ~newf & m_filt & m_fall;
    w1c = (m_wr && m_wofs == 2'd3) ? m_wdat : 8'h00;
    if (m_wr && m_wofs == 2'd1) m_rise = m_wdat;
    if (m_wr && m_wofs == 2'd2) m_fall = m_wdat;
    m_status = (m_status & ~w1c) | rs | fl;
    m_filt   = newf;
    m_wr     = 1'b0;
  endtask

  task automatic tick();
    @(posedge iCLK);
    if (iSTB && !m_busy) begin
      m_busy = 1'b1;
      m_snap = model_reg(iADR[3:2]);
      m_wr   = iWE;
      m_wofs = iADR[3:2];
      m_wdat = iDAT[7:0];
    end else if (!iSTB) begin
      m_busy = 1'b0;
    end
    model_step();
    @(negedge iCLK);
  endtask

  task automatic bus_wr(input logic [1:0] o, input logic [31:0] d);
    iSTB = 1'b1; iWE = 1'b1; iADR = {28'h0, o, 2'b00}; iDAT = d;
    tick();
    iSTB = 1'b0; iWE = 1'b0;
    tick();
  endtask

  task automatic bus_rd(input logic [1:0] o, output logic [31:0] d,
                        output logic [31:0] e, output int acks);
    iSTB = 1'b1; iWE = 1'b0; iADR = {28'h0, o, 2'b00};
    tick();
    acks = int'(oACK);
    d    = oDAT;
    e    = m_snap;
    iSTB = 1'b0;
    tick();
    acks += int'(oACK);
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    int a;
    #1 iRSTn = 1'b0;
    #3;
    vectors++; if ({oACK, oIRQ} !== 2'b00) begin miscompares++; $display("FAIL reset_ack_irq: got %b want 00", {oACK, oIRQ}); end
    vectors++; if (oDAT !== 32'h0) begin miscompares++; $display("FAIL reset_odat: got %h want 00000000", oDAT); end
    #8 iRSTn = 1'b1;
    model_reset();
    @(negedge iCLK);
    for (int unsigned o = 0; o < 4; o++) begin
      bus_rd(2'(o), d, e, a);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_read ofs%0d: got %h want 00000000", o, d); end
      vectors++; if (a !== 1) begin miscompares++; $display("FAIL reset_ack_count ofs%0d: got %0d want 1", o, a); end
    end
    vectors++; if (oIRQ !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", oIRQ); end
  endtask

  task automatic test_data_latency();
    logic [31:0] d, e;
    int a;
    iDIn = 8'hAB;
    repeat (4) tick();
    bus_rd(2'd0, d, e, a);  // samples edge 5
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL latency_edge5: got %h want 00000000", d); end
    vectors++; if (e !== 32'h0) begin miscompares++; $display("FAIL latency_model5: got %h want 00000000", e); end
    bus_rd(2'd0, d, e, a);  // samples edge 7
    vectors++; if (d !== 32'h0000_00AB) begin miscompares++; $display("FAIL latency_edge7: got %h want 000000ab", d); end
    vectors++; if (d !== e) begin miscompares++; $display("FAIL latency_model7: got %h want %h", d, e); end
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    int a;
    iDIn = 8'h00;
    repeat (8) tick();
    iDIn = 8'h01;
    repeat (3) tick();
    iDIn = 8'h00;
    repeat (8) begin
      tick();
      vectors++; if (oIRQ !== 1'b0) begin miscompares++; $display("FAIL glitch_irq: got %b want 0", oIRQ); end
    end
    bus_rd(2'd0, d, e, a);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL glitch_data: got %h want 00000000", d); end
    bus_rd(2'd3, d, e, a);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL glitch_status: got %h want 00000000", d); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d, e;
    int a;
    bus_wr(2'd1, 32'h0000_0001);
    bus_wr(2'd2, 32'h0000_0080);
    iDIn = 8'h80;
    repeat (8) tick();
    bus_rd(2'd3, d, e, a);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL edge_unenabled: got %h want 00000000", d); end
    iDIn = 8'h01;
    repeat (8) tick();
    vectors++; if (oIRQ !== 1'b1) begin miscompares++; $display("FAIL edge_irq_set: got %b want 1", oIRQ); end
    bus_rd(2'd3, d, e, a);
    vectors++; if (d !== 32'h0000_0081) begin miscompares++; $display("FAIL edge_status: got %h want 00000081", d); end
    bus_wr(2'd3, 32'h0000_0001);
    bus_rd(2'd3, d, e, a);
    vectors++; if (d !== 32'h0000_0080) begin miscompares++; $display("FAIL edge_w1c_bit0: got %h want 00000080", d); end
    bus_wr(2'd3, 32'h0000_0080);
    vectors++; if (oIRQ !== 1'b0) begin miscompares++; $display("FAIL edge_irq_clear: got %b want 0", oIRQ); end
    bus_wr(2'd0, 32'hFFFF_FFFF);
    bus_rd(2'd0, d, e, a);
    vectors++; if (d !== 32'h0000_0001) begin miscompares++; $display("FAIL data_readonly: got %h want 00000001", d); end
    bus_wr(2'd2, 32'hFFFF_FF80);
    bus_rd(2'd2, d, e, a);
    vectors++; if (d !== 32'h0000_0080) begin miscompares++; $display("FAIL upper_bits: got %h want 00000080", d); end
  endtask

  task automatic test_held_strobe();
    logic [31:0] d, e;
    int a, acks;
    acks = 0;
    iSTB = 1'b1; iWE = 1'b1; iADR = 32'h4; iDAT = 32'h0000_000F;
    repeat (4) begin tick(); acks += int'(oACK); end
    iSTB = 1'b0; iWE = 1'b0;
    repeat (3) begin tick(); acks += int'(oACK); end
    vectors++; if (acks !== 1) begin miscompares++; $display("FAIL held_ack_count: got %0d want 1", acks); end
    bus_rd(2'd1, d, e, a);
    vectors++; if (d !== 32'h0000_000F) begin miscompares++; $display("FAIL held_rise_en: got %h want 0000000f", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    int a;
    bus_wr(2'd1, 32'h0000_00FF);
    iDIn = 8'h55;
    repeat (2) tick();
    iSTB = 1'b1; iWE = 1'b0; iADR = 32'h0;
    tick();
    vectors++; if (oACK !== 1'b1) begin miscompares++; $display("FAIL mid_ack_before: got %b want 1", oACK); end
    iSTB = 1'b0;
    #2 iRSTn = 1'b0;
    #1 iRSTn = 1'b1;
    model_reset();
    vectors++; if ({oACK, oIRQ} !== 2'b00) begin miscompares++; $display("FAIL mid_ack_irq: got %b want 00", {oACK, oIRQ}); end
    vectors++; if (oDAT !== 32'h0) begin miscompares++; $display("FAIL mid_odat: got %h want 00000000", oDAT); end
    repeat (4) begin
      tick();
      vectors++; if (oACK !== 1'b0) begin miscompares++; $display("FAIL mid_spurious_ack: got %b want 0", oACK); end
    end
    bus_rd(2'd0, d, e, a);  // samples edge 5 after release
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL mid_data_early: got %h want 00000000", d); end
    bus_rd(2'd0, d, e, a);  // samples edge 7 after release
    vectors++; if (d !== 32'h0000_0055) begin miscompares++; $display("FAIL mid_data_late: got %h want 00000055", d); end
    bus_rd(2'd3, d, e, a);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL mid_status: got %h want 00000000", d); end
    vectors++; if (oIRQ !== 1'b0) begin miscompares++; $display("FAIL mid_irq: got %b want 0", oIRQ); end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    int a;
    int unsigned hold;
    bus_wr(2'd1, $urandom);
    bus_wr(2'd2, $urandom);
    for (int unsigned seg = 0; seg < 40; seg++) begin
      iDIn = 8'($urandom);
      hold = $urandom_range(1, 9);
      for (int unsigned c = 0; c < hold; c++) begin
        tick();
        vectors++; if (oIRQ !== (|m_status)) begin miscompares++; $display("FAIL rand_irq seg%0d: got %b want %b", seg, oIRQ, |m_status); end
      end
      bus_rd(2'd0, d, e, a);
      vectors++; if (d !== e) begin miscompares++; $display("FAIL rand_data seg%0d: got %h want %h", seg, d, e); end
      vectors++; if (a !== 1) begin miscompares++; $display("FAIL rand_ack seg%0d: got %0d want 1", seg, a); end
      if ($urandom_range(0, 2) == 0) begin
        bus_rd(2'd3, d, e, a);
        vectors++; if (d !== e) begin miscompares++; $display("FAIL rand_status seg%0d: got %h want %h", seg, d, e); end
      end
      if ($urandom_range(0, 3) == 0) bus_wr(2'd3, $urandom);
      if ($urandom_range(0, 7) == 0) bus_wr(2'($urandom_range(1, 2)), $urandom);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_data_latency();
    test_glitch();
    test_edge_irq();
    test_held_strobe();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
